uart_console_rx: RTL and testbench
==================================

// Module: uart_console_rx
// PURPOSE
//  Host-to-core UART receive path: 8N1 receiver (optional parity) with receive FIFO and a
//  load-mapped read port for RVCore console input. Complements the core-to-host tx queue.
//  Runs in the DRAM-controller clock domain, below the MMIO address decode.
// PARAMETERS
//  CLK_HZ      166_670_000  input clock frequency
//  BAUD        1_000_000    line rate; DIV = round(CLK_HZ/BAUD) = 167 at defaults
//  FIFO_DEPTH  16           receive FIFO entries, power of two, >=2
// PORTS
//  clk_166_67_mhz   in   1   clock
//  dram_rstx_async  in   1   reset, asynchronous, active-low
//  i_rxd            in   1   raw serial line, idle high, asynchronous
//  i_ren            in   1   pop request (MMIO load of RX data register)
//  i_stall          in   1   memory stall; i_ren ignored while high
//  i_clr            in   1   clear sticky error flags
//  o_rdata          out  32  {valid,overrun,frame_err,parity_err,20'b0,char[7:0]}
//  o_count          out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  o_nempty         out  1   FIFO non-empty (interrupt/poll)
// BEHAVIOUR
//  - Reset: all outputs 0, sync flops 1, FSM IDLE, FIFO empty, sticky flags 0.
//  - i_rxd through 2-FF synchroniser (init 1); FSM uses synchronised value only.
//  - FSM: IDLE -> START on high-to-low. START: wait DIV/2 cycles, resample;
//    low -> DATA, high -> IDLE (glitch rejected).
//  - DATA: 8 samples spaced DIV cycles, LSB first -> PARITY (if enabled) or STOP.
//  - STOP: sample after DIV. 1 -> push byte, IDLE. 0 -> frame_err set, byte discarded,
//    go to BREAK; BREAK returns to IDLE once line sampled high.
//  - Push latency: byte visible (o_count incremented) 1 cycle after stop-bit sample.
//  - Pop: i_ren & !i_stall. o_rdata registered, valid next cycle, held until next pop.
//    Non-empty: valid=1, char=head, head advances. Empty: valid=0, char=0, no state change.
//  - Full at push: byte dropped, overrun set, unless a pop is accepted the same cycle
//    (pop then push both take effect, count unchanged).
//  - Simultaneous push+pop otherwise: count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  - Sticky flags (overrun, frame_err, parity_err) mirrored in o_rdata[30:28] on every pop;
//    cleared by i_clr, but an error event in the same cycle as i_clr wins (flag stays 1).
//  - Reset mid-frame: frame abandoned, FIFO contents lost.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: 8E1 frame; PARITY state samples 9th bit; parity mismatch sets
//   parity_err and discards byte (stop still checked).
//  Not defined: 8N1, no PARITY state, parity_err constant 0.
// STRUCTURE
//  Package uart_rx_pkg: FSM state enum (IDLE,START,DATA,PARITY,STOP,BREAK), rdata field
//  bit positions, div_calc(CLK_HZ,BAUD) constant function.
//  Sub-module rx_sync_fifo: width 8, depth FIFO_DEPTH, push/pop/count/full/empty.
// TESTING
//  - Send 0x55 at 1 Mbaud, then i_ren -> o_count 0->1 after stop; o_rdata=0x8000_0055; count 0.
//  - i_ren while empty -> o_rdata=0x0000_0000, count stays 0, no flag change.
//  - Low glitch of 40 cycles on i_rxd -> no push, FSM back to IDLE, count 0.
//  - Frame 0xA3 with stop bit 0 -> no push, frame_err=1; next 0x41 read as 0xA000_0041;
//    i_clr then pop-empty -> 0x0000_0000.
//  - 17 bytes 0x00..0x10, no reads -> count 16, overrun=1; 16 pops return 0x00..0x0F in order.
//  - Full FIFO, i_ren coincident with push of 0x7E -> no overrun, count 16, 0x7E last out;
//    with UART_RX_PARITY_EN, odd parity on 0x01 -> parity_err=1, count unchanged.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the console UART receive path:
// FSM state encoding, o_rdata field positions and the baud divider helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rxState_t;

    localparam int RDATA_VALID   = 31;
    localparam int RDATA_OVERRUN = 30;
    localparam int RDATA_FRAME   = 29;
    localparam int RDATA_PARITY  = 28;

    // Clocks per bit, rounded to the nearest whole clock
    function automatic int div_calc(input int clkHz, input int baud);
        return (clkHz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock receive FIFO with a registered occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module rx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_166_67_mhz,
    input  logic                     dram_rstx_async,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         pushData_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         headData_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             wrEn;
    logic             rdEn;

    assign full_o     = (count_q == FULL_COUNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign headData_o = mem_q[rdPtr_q];
    assign wrEn       = push_i & (~full_o | pop_i);
    assign rdEn       = pop_i & ~empty_o;

    always_ff @(posedge clk_166_67_mhz) begin
        if (wrEn) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
        if (!dram_rstx_async) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (wrEn) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (rdEn) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({wrEn, rdEn})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_console_rx.sv
// Console UART receiver: line synchroniser, frame FSM, receive FIFO and MMIO pop port.
// Define UART_RX_PARITY_EN for 8E1 framing; the default build is 8N1 with parity_err tied 0.
module uart_console_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 166_670_000,
    parameter int BAUD       = 1_000_000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_166_67_mhz,
    input  logic                          dram_rstx_async,
    input  logic                          i_rxd,
    input  logic                          i_ren,
    input  logic                          i_stall,
    input  logic                          i_clr,
    output logic [31:0]                   o_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_nempty
);

    localparam int DIV  = div_calc(CLK_HZ, BAUD);
    localparam int HALF = DIV / 2;
    localparam int TW   = $clog2(DIV + 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(DIV - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(HALF - 1);
`ifdef UART_RX_PARITY_EN
    localparam rxState_t AFTER_DATA = PARITY;
`else
    localparam rxState_t AFTER_DATA = STOP;
`endif

    logic                         rxMeta_q;
    logic                         rxSync_q;
    logic                         rxPrev_q;
    rxState_t                     state_q;
    logic [TW-1:0]                tick_q;
    logic [2:0]                   bitIdx_q;
    logic [7:0]                   shift_q;
    logic                         push_q;
    logic [7:0]                   pushData_q;
    logic                         frameEvt_q;
`ifdef UART_RX_PARITY_EN
    logic                         parityBad_q;
    logic                         parityEvt_q;
`endif
    logic                         overrun_q;
    logic                         frameErr_q;
    logic                         parityErr_q;
    logic                         overrun_d;
    logic                         frameErr_d;
    logic                         parityErr_d;
    logic [31:0]                  rdata_q;
    logic [31:0]                  rdata_d;
    logic                         popAccept;
    logic                         fifoPop;
    logic                         fifoFull;
    logic                         fifoEmpty;
    logic                         overrunEvt;
    logic [7:0]                   headData;
    logic [$clog2(FIFO_DEPTH):0]  fifoCount;

    always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
        if (!dram_rstx_async) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= i_rxd;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    // Frame FSM; the push and error strobes leave it registered for one cycle
    always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
        if (!dram_rstx_async) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            pushData_q  <= '0;
            frameEvt_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBad_q <= 1'b0;
            parityEvt_q <= 1'b0;
`endif
        end else begin
            push_q     <= 1'b0;
            frameEvt_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityEvt_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    tick_q <= '0;
`ifdef UART_RX_PARITY_EN
                    parityBad_q <= 1'b0;
`endif
                    if (rxPrev_q && !rxSync_q) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick_q == TICK_HALF) begin
                        tick_q   <= '0;
                        bitIdx_q <= '0;
                        state_q  <= rxSync_q ? IDLE : DATA;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == TICK_FULL) begin
                        tick_q   <= '0;
                        shift_q  <= {rxSync_q, shift_q[7:1]};
                        bitIdx_q <= bitIdx_q + 1'b1;
                        if (bitIdx_q == 3'd7) begin
                            state_q <= AFTER_DATA;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_q == TICK_FULL) begin
                        tick_q  <= '0;
                        state_q <= STOP;
                        if (rxSync_q != ^shift_q) begin
                            parityBad_q <= 1'b1;
                            parityEvt_q <= 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick_q == TICK_FULL) begin
                        tick_q <= '0;
                        if (rxSync_q) begin
`ifdef UART_RX_PARITY_EN
                            push_q <= ~parityBad_q;
`else
                            push_q <= 1'b1;
`endif
                            pushData_q <= shift_q;
                            state_q    <= IDLE;
                        end else begin
                            frameEvt_q <= 1'b1;
                            state_q    <= BREAK;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxSync_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign popAccept  = i_ren & ~i_stall;
    assign fifoPop    = popAccept & ~fifoEmpty;
    assign overrunEvt = push_q & fifoFull & ~fifoPop;

    rx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_166_67_mhz  (clk_166_67_mhz),
        .dram_rstx_async (dram_rstx_async),
        .push_i          (push_q),
        .pushData_i      (pushData_q),
        .pop_i           (fifoPop),
        .headData_o      (headData),
        .count_o         (fifoCount),
        .full_o          (fifoFull),
        .empty_o         (fifoEmpty)
    );

    // An error event in the same cycle as i_clr keeps its flag set
    always_comb begin
        overrun_d  = (overrun_q & ~i_clr) | overrunEvt;
        frameErr_d = (frameErr_q & ~i_clr) | frameEvt_q;
`ifdef UART_RX_PARITY_EN
        parityErr_d = (parityErr_q & ~i_clr) | parityEvt_q;
`else
        parityErr_d = 1'b0;
`endif
        rdata_d = rdata_q;
        if (popAccept) begin
            rdata_d                = '0;
            rdata_d[RDATA_VALID]   = ~fifoEmpty;
            rdata_d[RDATA_OVERRUN] = overrun_q;
            rdata_d[RDATA_FRAME]   = frameErr_q;
            rdata_d[RDATA_PARITY]  = parityErr_q;
            rdata_d[7:0]           = fifoEmpty ? 8'h00 : headData;
        end
    end

    always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
        if (!dram_rstx_async) begin
            overrun_q   <= 1'b0;
            frameErr_q  <= 1'b0;
            parityErr_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            overrun_q   <= overrun_d;
            frameErr_q  <= frameErr_d;
            parityErr_q <= parityErr_d;
            rdata_q     <= rdata_d;
        end
    end

    assign o_rdata  = rdata_q;
    assign o_count  = fifoCount;
    assign o_nempty = ~fifoEmpty;

endmodule

// File: tb/tb_uart_console_rx.sv
// Directed bench for uart_console_rx: a byte-queue model of the receive FIFO and sticky flags
// is compared against the DUT every cycle the line is quiet, plus literal spot checks.
module tb_uart_console_rx;

    localparam int DIV   = 167;
    localparam int HALF  = 83;
    localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif
    localparam int FRAME_BITS = 9 + int'(PARITY_ON);
    // start-edge sync + edge detect, half bit, remaining bit periods, push latency
    localparam int POP_AT = 3 + HALF + FRAME_BITS * DIV + 1;

    logic        clk_166_67_mhz = 1'b0;
    logic        dram_rstx_async = 1'b0;
    logic        i_rxd = 1'b1;
    logic        i_ren = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_clr = 1'b0;
    logic [31:0] o_rdata;
    logic [4:0]  o_count;
    logic        o_nempty;

    int          nChecks = 0;
    int          nFail = 0;
    logic [7:0]  modelQ[$];
    logic        mOvr = 1'b0;
    logic        mFrm = 1'b0;
    logic        mPar = 1'b0;
    logic [31:0] expRdata = 32'h0;
    logic        checkEn = 1'b0;

    always #3 clk_166_67_mhz = ~clk_166_67_mhz;

    uart_console_rx dut (
        .clk_166_67_mhz  (clk_166_67_mhz),
        .dram_rstx_async (dram_rstx_async),
        .i_rxd           (i_rxd),
        .i_ren           (i_ren),
        .i_stall         (i_stall),
        .i_clr           (i_clr),
        .o_rdata         (o_rdata),
        .o_count         (o_count),
        .o_nempty        (o_nempty)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Continuous compare against the model while no frame is in flight
    always @(posedge clk_166_67_mhz) begin
        #1;
        if (checkEn) begin
            checkOutput("count", 32'(o_count), 32'(modelQ.size()));
            checkOutput("nempty", 32'(o_nempty), 32'(modelQ.size() != 0));
            checkOutput("rdata", o_rdata, expRdata);
        end
    end

    task automatic modelPop();
        if (modelQ.size() != 0) begin
            expRdata = {1'b1, mOvr, mFrm, mPar, 20'h0, modelQ.pop_front()};
        end else begin
            expRdata = {1'b0, mOvr, mFrm, mPar, 28'h0};
        end
    endtask

    task automatic doPop(input logic stall);
        @(negedge clk_166_67_mhz);
        i_ren   = 1'b1;
        i_stall = stall;
        if (!stall) begin
            modelPop();
        end
        @(negedge clk_166_67_mhz);
        i_ren   = 1'b0;
        i_stall = 1'b0;
    endtask

    task automatic doClear();
        @(negedge clk_166_67_mhz);
        i_clr = 1'b1;
        mOvr  = 1'b0;
        mFrm  = 1'b0;
        mPar  = 1'b0;
        @(negedge clk_166_67_mhz);
        i_clr = 1'b0;
    endtask

    // Sends one frame; popAt > 0 fires a single pop that many clocks after the start bit
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input logic parityFlip, input int popAt);
        logic badParity;
        badParity = parityFlip && PARITY_ON;
        checkEn   = 1'b0;
        fork
            begin
                @(negedge clk_166_67_mhz);
                i_rxd = 1'b0;
                repeat (DIV) @(negedge clk_166_67_mhz);
                for (int i = 0; i < 8; i++) begin
                    i_rxd = data[i];
                    repeat (DIV) @(negedge clk_166_67_mhz);
                end
                if (PARITY_ON) begin
                    i_rxd = (^data) ^ parityFlip;
                    repeat (DIV) @(negedge clk_166_67_mhz);
                end
                i_rxd = stopBit;
                repeat (DIV) @(negedge clk_166_67_mhz);
                i_rxd = 1'b1;
                repeat (10) @(negedge clk_166_67_mhz);
            end
            begin
                if (popAt > 0) begin
                    @(negedge clk_166_67_mhz);
                    repeat (popAt - 1) @(posedge clk_166_67_mhz);
                    @(negedge clk_166_67_mhz);
                    i_ren = 1'b1;
                    modelPop();
                    @(negedge clk_166_67_mhz);
                    i_ren = 1'b0;
                end
            end
        join
        if (!stopBit) begin
            mFrm = 1'b1;
        end else if (badParity) begin
            mPar = 1'b1;
        end else if (modelQ.size() == DEPTH) begin
            mOvr = 1'b1;
        end else begin
            modelQ.push_back(data);
        end
        checkEn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (4) @(negedge clk_166_67_mhz);
        checkOutput("reset_rdata", o_rdata, 32'h0);
        checkOutput("reset_count", 32'(o_count), 32'h0);
        checkOutput("reset_nempty", 32'(o_nempty), 32'h0);
        dram_rstx_async = 1'b1;
        repeat (4) @(negedge clk_166_67_mhz);
        checkEn = 1'b1;

        // Single byte then read it back
        applyStimulus(8'h55, 1'b1, 1'b0, 0);
        checkOutput("count_after_55", 32'(o_count), 32'd1);
        doPop(1'b0);
        checkOutput("rdata_55", o_rdata, 32'h8000_0055);
        checkOutput("count_after_pop", 32'(o_count), 32'd0);

        // Empty pop and a stalled pop
        doPop(1'b0);
        checkOutput("rdata_empty", o_rdata, 32'h0000_0000);
        applyStimulus(8'hC3, 1'b1, 1'b0, 0);
        doPop(1'b1);
        checkOutput("stall_count", 32'(o_count), 32'd1);
        doPop(1'b0);
        checkOutput("rdata_c3", o_rdata, 32'h8000_00C3);

        // Short low glitch must not start a frame
        @(negedge clk_166_67_mhz);
        i_rxd = 1'b0;
        repeat (40) @(negedge clk_166_67_mhz);
        i_rxd = 1'b1;
        repeat (2 * DIV) @(negedge clk_166_67_mhz);
        checkOutput("glitch_count", 32'(o_count), 32'd0);

        // Framing error, then a good byte carries the sticky flag
        applyStimulus(8'hA3, 1'b0, 1'b0, 0);
        checkOutput("frame_count", 32'(o_count), 32'd0);
        applyStimulus(8'h41, 1'b1, 1'b0, 0);
        doPop(1'b0);
        checkOutput("rdata_41", o_rdata, 32'hA000_0041);
        doClear();
        doPop(1'b0);
        checkOutput("rdata_clr", o_rdata, 32'h0000_0000);

        // Overflow: 17 bytes into 16 entries
        for (int b = 0; b < 17; b++) begin
            applyStimulus(8'(b), 1'b1, 1'b0, 0);
        end
        checkOutput("count_full", 32'(o_count), 32'd16);
        doPop(1'b0);
        checkOutput("rdata_ovr_first", o_rdata, 32'hC000_0000);
        for (int b = 1; b < 16; b++) begin
            doPop(1'b0);
        end
        checkOutput("rdata_ovr_last", o_rdata, 32'hC000_000F);

        // Full FIFO with a pop landing on the push cycle
        doClear();
        for (int b = 0; b < 16; b++) begin
            applyStimulus(8'h20 + 8'(b), 1'b1, 1'b0, 0);
        end
        applyStimulus(8'h7E, 1'b1, 1'b0, POP_AT);
        checkOutput("count_coincident", 32'(o_count), 32'd16);
        for (int b = 0; b < 16; b++) begin
            doPop(1'b0);
        end
        checkOutput("rdata_7e_last", o_rdata, 32'h8000_007E);
        doPop(1'b0);
        checkOutput("rdata_drained", o_rdata, 32'h0000_0000);

        if (PARITY_ON) begin
            applyStimulus(8'h01, 1'b1, 1'b1, 0);
            checkOutput("parity_count", 32'(o_count), 32'd0);
            applyStimulus(8'h02, 1'b1, 1'b0, 0);
            doPop(1'b0);
            checkOutput("rdata_parity", o_rdata, 32'h9000_0002);
        end

        repeat (4) @(negedge clk_166_67_mhz);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
